// File: rtl/interrupt_controller.sv
// interrupt_controller
//
// Collects eight asynchronous device interrupt lines, latches their rising edges into pending
// bits, applies a software mask and presents a single request plus a stable vector to the
// microcode sequencer.
//
// Ports:
//   clk                  system clock, rising edge
//   arst                 asynchronous active-high reset
//   irq_in[7:0]          device interrupt lines (asynchronous, rising-edge triggered)
//   z_bus[7:0]           write data for mask and vector-base registers
//   ctrl_irq_masks_wrt   active-low mask write strobe (irq_masks <= z_bus)
//   ctrl_int_vector_wrt  active-low vector-base write strobe (vector_base <= z_bus[7:4])
//   ctrl_int_ack         acknowledge the highest-priority unmasked pending line
//   ctrl_clear_all_ints  clear every pending bit
//   int_pending          any unmasked pending line
//   int_vector[7:0]      {vector_base, active_index, 1'b0}
//   irq_masks[7:0]       mask register, 1 = enabled
//   irq_status[7:0]      raw pending bits before masking
module interrupt_controller (
   input  logic       clk,
   input  logic       arst,
   input  logic [7:0] irq_in,
   input  logic [7:0] z_bus,
   input  logic       ctrl_irq_masks_wrt,
   input  logic       ctrl_int_vector_wrt,
   input  logic       ctrl_int_ack,
   input  logic       ctrl_clear_all_ints,
   output logic       int_pending,
   output logic [7:0] int_vector,
   output logic [7:0] irq_masks,
   output logic [7:0] irq_status
);

   logic [7:0] s1_q;
   logic [7:0] s2_q;
   logic [7:0] prev_q;
   logic [7:0] pending_q;
   logic [7:0] pending_d;
   logic [7:0] masks_q;
   logic [3:0] vector_base_q;
   logic [2:0] active_index_q;

   logic [7:0] edge_det;
   logic [7:0] masked;
   logic [2:0] sel_index;
   logic       sel_valid;
   logic       ack_take;

   assign edge_det = s2_q & ~prev_q;
   assign masked   = pending_q & masks_q;
   assign ack_take = ctrl_int_ack & sel_valid;

   // Lowest index wins; scanning downward leaves the lowest set bit as the final assignment.
   always_comb begin
      sel_index = 3'd0;
      sel_valid = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         if (masked[i]) begin
            sel_index = 3'(i);
            sel_valid = 1'b1;
         end
      end
   end

   // Per-bit precedence: clear-all, then a new edge, then the ack clear.
   always_comb begin
      pending_d = pending_q;
      if (ack_take) begin
         pending_d[sel_index] = 1'b0;
      end
      pending_d = pending_d | edge_det;
      if (ctrl_clear_all_ints) begin
         pending_d = 8'h00;
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         s1_q           <= 8'h00;
         s2_q           <= 8'h00;
         prev_q         <= 8'h00;
         pending_q      <= 8'h00;
         masks_q        <= 8'h00;
         vector_base_q  <= 4'h0;
         active_index_q <= 3'd0;
      end else begin
         s1_q      <= irq_in;
         s2_q      <= s1_q;
         prev_q    <= s2_q;
         pending_q <= pending_d;
         if (!ctrl_irq_masks_wrt) begin
            masks_q <= z_bus;
         end
         if (!ctrl_int_vector_wrt) begin
            vector_base_q <= z_bus[7:4];
         end
         if (ack_take) begin
            active_index_q <= sel_index;
         end
      end
   end

   assign int_pending = |masked;
   assign int_vector  = {vector_base_q, active_index_q, 1'b0};
   assign irq_masks   = masks_q;
   assign irq_status  = pending_q;

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

   logic       clk;
   logic       arst;
   logic [7:0] irq_in;
   logic [7:0] z_bus;
   logic       ctrl_irq_masks_wrt;
   logic       ctrl_int_vector_wrt;
   logic       ctrl_int_ack;
   logic       ctrl_clear_all_ints;
   logic       int_pending;
   logic [7:0] int_vector;
   logic [7:0] irq_masks;
   logic [7:0] irq_status;

   int n_vec = 0;
   int n_err = 0;

   interrupt_controller dut (
      .clk                 (clk),
      .arst                (arst),
      .irq_in              (irq_in),
      .z_bus               (z_bus),
      .ctrl_irq_masks_wrt  (ctrl_irq_masks_wrt),
      .ctrl_int_vector_wrt (ctrl_int_vector_wrt),
      .ctrl_int_ack        (ctrl_int_ack),
      .ctrl_clear_all_ints (ctrl_clear_all_ints),
      .int_pending         (int_pending),
      .int_vector          (int_vector),
      .irq_masks           (irq_masks),
      .irq_status          (irq_status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model. hist[k] is irq_in as sampled k+1 edges ago; a line counts as newly risen
   // when it was seen high two edges ago after being low three edges ago.
   logic [7:0] hist [3];
   logic [7:0] m_pend;
   logic [7:0] m_mask;
   logic [3:0] m_vbase;
   logic [2:0] m_active;

   function automatic int lowest_enabled(input logic [7:0] p, input logic [7:0] m);
      for (int i = 0; i < 8; i++) begin
         if (p[i] && m[i]) return i;
      end
      return -1;
   endfunction

   always @(posedge clk or posedge arst) begin
      if (arst) begin
         hist[0]  <= 8'h00;
         hist[1]  <= 8'h00;
         hist[2]  <= 8'h00;
         m_pend   <= 8'h00;
         m_mask   <= 8'h00;
         m_vbase  <= 4'h0;
         m_active <= 3'd0;
      end else begin
         logic [7:0] rose;
         logic [7:0] np;
         int         sel;
         rose = hist[1] & ~hist[2];
         sel  = lowest_enabled(m_pend, m_mask);
         np   = m_pend;
         if (ctrl_int_ack && sel >= 0) begin
            np[sel] = 1'b0;
            m_active <= 3'(sel);
         end
         np = np | rose;
         if (ctrl_clear_all_ints) np = 8'h00;
         m_pend  <= np;
         hist[0] <= irq_in;
         hist[1] <= hist[0];
         hist[2] <= hist[1];
         if (!ctrl_irq_masks_wrt) m_mask <= z_bus;
         if (!ctrl_int_vector_wrt) m_vbase <= z_bus[7:4];
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wr_mask(input logic [7:0] v);
      z_bus = v;
      ctrl_irq_masks_wrt = 1'b0;
      tick();
      ctrl_irq_masks_wrt = 1'b1;
   endtask

   task automatic wr_vec(input logic [7:0] v);
      z_bus = v;
      ctrl_int_vector_wrt = 1'b0;
      tick();
      ctrl_int_vector_wrt = 1'b1;
   endtask

   task automatic ack();
      ctrl_int_ack = 1'b1;
      tick();
      ctrl_int_ack = 1'b0;
   endtask

   task automatic compare_loop();
      forever begin
         @(negedge clk);
         if (!arst) begin
            chk("model int_pending", {7'd0, int_pending}, {7'd0, |(m_pend & m_mask)});
            chk("model int_vector", int_vector, {m_vbase, m_active, 1'b0});
            chk("model irq_masks", irq_masks, m_mask);
            chk("model irq_status", irq_status, m_pend);
         end
      end
   endtask

   task automatic directed();
      // Basic request, ack and vector
      wr_mask(8'hFF);
      wr_vec(8'hA0);
      irq_in = 8'h08;
      ticks(2);
      chk("edge latency not early", irq_status, 8'h00);
      tick();
      chk("basic status", irq_status, 8'h08);
      chk("basic int_pending", {7'd0, int_pending}, 8'h01);
      irq_in = 8'h00;
      ack();
      chk("basic ack status", irq_status, 8'h00);
      chk("basic ack int_pending", {7'd0, int_pending}, 8'h00);
      chk("basic vector", int_vector, 8'hA6);

      // Priority
      irq_in = 8'h24;
      ticks(3);
      irq_in = 8'h00;
      chk("prio status", irq_status, 8'h24);
      ack();
      chk("prio first vector", int_vector, 8'hA4);
      chk("prio first status", irq_status, 8'h20);
      ack();
      chk("prio second vector", int_vector, 8'hAA);
      chk("prio second status", irq_status, 8'h00);

      // Masking
      wr_mask(8'hF7);
      irq_in = 8'h08;
      ticks(3);
      irq_in = 8'h00;
      chk("mask status", irq_status, 8'h08);
      chk("mask int_pending", {7'd0, int_pending}, 8'h00);
      ack();
      chk("mask ack status", irq_status, 8'h08);
      chk("mask ack vector", int_vector, 8'hAA);
      wr_mask(8'hFF);
      chk("unmask int_pending", {7'd0, int_pending}, 8'h01);
      ack();
      chk("unmask ack vector", int_vector, 8'hA6);

      // New edge on the bit being acked keeps it pending
      irq_in = 8'h01;
      ticks(3);
      irq_in = 8'h00;
      chk("line0 status", irq_status, 8'h01);
      ticks(3);
      irq_in = 8'h01;
      ticks(2);
      ctrl_int_ack = 1'b1;
      tick();
      ctrl_int_ack = 1'b0;
      chk("ack vs edge status", irq_status, 8'h01);
      chk("ack vs edge vector", int_vector, 8'hA0);
      irq_in = 8'h00;
      ticks(3);
      ack();
      chk("line0 cleared", irq_status, 8'h00);

      // Clear-all beats a same-edge detection
      irq_in = 8'h02;
      ticks(2);
      ctrl_clear_all_ints = 1'b1;
      tick();
      ctrl_clear_all_ints = 1'b0;
      chk("clear vs edge", irq_status, 8'h00);
      irq_in = 8'h00;
      ticks(2);
      chk("clear stays", irq_status, 8'h00);

      // Asynchronous reset mid-cycle
      irq_in = 8'h81;
      ticks(3);
      irq_in = 8'h80;
      chk("pre-reset status", irq_status, 8'h81);
      #3;
      arst = 1'b1;
      #1;
      chk("async rst int_pending", {7'd0, int_pending}, 8'h00);
      chk("async rst int_vector", int_vector, 8'h00);
      chk("async rst irq_masks", irq_masks, 8'h00);
      chk("async rst irq_status", irq_status, 8'h00);
      @(posedge clk);
      #3;
      arst = 1'b0;
      ticks(2);
      chk("held line not early", irq_status, 8'h00);
      tick();
      chk("held line edge", irq_status, 8'h80);
      ticks(4);
      chk("held line still", irq_status, 8'h80);
      wr_mask(8'hFF);
      chk("held line int_pending", {7'd0, int_pending}, 8'h01);
      ack();
      chk("held line vector", int_vector, 8'h0E);
      ticks(4);
      chk("held line no re-edge", irq_status, 8'h00);
      irq_in = 8'h00;
      ticks(3);
   endtask

   task automatic random_phase();
      for (int c = 0; c < 3000; c++) begin
         irq_in              = irq_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
         z_bus               = 8'($urandom);
         ctrl_int_ack        = ($urandom_range(3) == 0);
         ctrl_clear_all_ints = ($urandom_range(19) == 0);
         ctrl_irq_masks_wrt  = ($urandom_range(9) != 0);
         ctrl_int_vector_wrt = ($urandom_range(9) != 0);
         if ($urandom_range(199) == 0) begin
            #1 arst = 1'b1;
            #1 arst = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      ctrl_int_ack        = 1'b0;
      ctrl_clear_all_ints = 1'b0;
      ctrl_irq_masks_wrt  = 1'b1;
      ctrl_int_vector_wrt = 1'b1;
      ticks(2);
   endtask

   initial begin
      arst                = 1'b1;
      irq_in              = 8'h00;
      z_bus               = 8'h00;
      ctrl_irq_masks_wrt  = 1'b1;
      ctrl_int_vector_wrt = 1'b1;
      ctrl_int_ack        = 1'b0;
      ctrl_clear_all_ints = 1'b0;
      #12;
      arst = 1'b0;
      #1;
      chk("reset int_pending", {7'd0, int_pending}, 8'h00);
      chk("reset int_vector", int_vector, 8'h00);
      chk("reset irq_masks", irq_masks, 8'h00);
      chk("reset irq_status", irq_status, 8'h00);
      fork
         compare_loop();
         begin
            directed();
            random_phase();
         end
      join_any
      disable fork;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Collects eight asynchronous device interrupt lines, latches rising edges into pending bits, applies a software mask, and presents a single `int_pending` request plus a stable vector to the microcode sequencer. It sits directly upstream of the sequencer. It feeds the sequencer's trap-dispatch decision and its interrupt-pending branch condition. It consumes the sequencer's `ctrl_int_ack`, `ctrl_clear_all_ints`, `ctrl_irq_masks_wrt` and `ctrl_int_vector_wrt` control bits, with write data taken from `z_bus`.

## Interface
- No parameters. The line count is fixed at 8.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `arst`  in  1  reset, asynchronous, active-high.
- `irq_in`  in  8  device interrupt lines; asynchronous, rising-edge triggered.
- `z_bus`  in  8  write data for the mask and vector-base registers.
- `ctrl_irq_masks_wrt`  in  1  active-low; loads `irq_masks <= z_bus`.
- `ctrl_int_vector_wrt`  in  1  active-low; loads `vector_base <= z_bus[7:4]`.
- `ctrl_int_ack`  in  1  active-high; acknowledges the highest-priority unmasked pending line.
- `ctrl_clear_all_ints`  in  1  active-high; clears every pending bit.
- `int_pending`  out  1  high when `|(pending & irq_masks)`; drives the sequencer.
- `int_vector`  out  8  `{vector_base, active_index, 1'b0}`.
- `irq_masks`  out  8  mask register; 1 = enabled.
- `irq_status`  out  8  raw pending bits, before masking.

## Operation
- **Synchronizer:** each `irq_in[i]` passes through two flops (`s1`, `s2`) and then an edge flop `prev`. An edge is detected when `s2[i] & ~prev[i]`.
- **Pending bits:**
  - A detected edge sets `pending[i]`.
  - Masked lines still latch. Masking only gates `int_pending`.
  - A line held high produces exactly one edge until it goes low and rises again.
- **Priority:**
  - `sel_index` is the lowest index `i` with `pending[i] & irq_masks[i]`. Bit 0 is the highest priority.
  - `sel_valid` is high when any such bit exists.
- **Acknowledge:** on a clk edge with `ctrl_int_ack=1` and `sel_valid=1`:
  - clear `pending[sel_index]`;
  - latch `active_index <= sel_index`.
- **Ack with no valid line:** when `ctrl_int_ack=1` and `sel_valid=0`, nothing changes.
- **Clear all:** `ctrl_clear_all_ints=1` clears all eight pending bits.
- **Register writes:**
  - The mask and vector writes are independent and may occur in the same cycle.
  - A mask write does not alter pending bits.
- **Simultaneous events, per bit, in priority order:**
  - `ctrl_clear_all_ints` beats everything: the bit ends at 0, even if a new edge arrives that cycle.
  - A new edge on the same bit being acked beats the ack: the bit stays 1, so the second request is not lost. `active_index` still updates.
  - A new edge on other bits during an ack sets those bits normally.
- **Reset values:**
  - `s1`, `s2`, `prev`, `pending`, `irq_masks`, `vector_base` and `active_index` are all 0.
  - Outputs: `int_pending=0`, `int_vector=8'h00`, `irq_masks=8'h00`, `irq_status=8'h00`.
  - A line already high when `arst` releases is seen as one edge.
- **Reset mid-operation:** assertion of `arst` clears all state immediately, without waiting for a clock. Pending requests are lost and the masks are disabled.

## Timing
- **Edge latency:** `irq_in[i]` rises before clk edge N (meeting setup).
  - `s1` is set at edge N and `s2` at edge N+1.
  - `pending[i]` is set at edge N+2.
  - `irq_status` and `int_pending` (if the line is unmasked) are high after edge N+2.
- **Input pulse width:** an `irq_in` pulse shorter than one clk period may be missed. Devices hold their lines for at least 2 clk cycles.
- **Combinational outputs:** `int_pending`, `sel_index` and `irq_masks` are combinational from registers. There is no input-to-output combinational path.
- **Ack effect:** after the ack edge, `int_pending` and `int_vector` reflect the new state.
  - `int_vector` is stable from the ack edge until the next valid ack, write or reset. The sequencer may read it in any later microcycle.
- **Write latency:** mask and vector writes take effect at the sampling edge and are visible the following cycle.
  - A mask write that enables an already-pending line raises `int_pending` in the cycle after that edge.

## Test plan
- **Basic request, ack and vector:** reset; write mask `8'hFF` and vector base `z_bus=8'hA0`; pulse `irq_in[3]` for 3 cycles.
  - `irq_status=8'h08` and `int_pending=1` exactly 3 edges after the rise.
  - Ack → `irq_status=0`, `int_pending=0`, `int_vector=8'hA6`.
- **Priority:** raise `irq_in[5]` and `irq_in[2]` together with mask `8'hFF`.
  - First ack → `int_vector[3:1]=2`, `irq_status=8'h20`.
  - Second ack → `int_vector[3:1]=5`, `irq_status=0`.
- **Masking:** mask `8'hF7`; edge on line 3 → `irq_status=8'h08`, `int_pending=0`.
  - Ack → no change, `int_vector` unchanged.
  - Write mask `8'hFF` → `int_pending=1` the next cycle.
- **Simultaneous events:**
  - A new line-0 edge detected on the same edge as its ack → `pending[0]` remains 1.
  - `ctrl_clear_all_ints` on the same edge as a line-1 detection → `irq_status=0`.
- **Reset:**
  - `arst` pulsed mid-clock while `irq_status=8'h81` → all outputs 0 before the next clk edge.
  - An `irq_in[7]` held high through reset release → `irq_status=8'h80` 3 edges later, and no second edge while it stays high.
